// File: rtl/oled_frame_streamer.sv
// oled_frame_streamer
//   SSD1306 frame engine. After reset it idles for PWR_DELAY cycles, sends a fixed
//   init command list, then streams a PAGES x COLS framebuffer (read from an external
//   synchronous RAM) to a byte-level I2C master using its start/busy handshake.
//
// Ports
//   clk_i           system clock
//   rst_i           asynchronous, active-high reset
//   cont_i          1: start the next frame straight after the current one ends
//   frame_req_i     1-cycle pulse requesting one frame
//   fb_addr_o       framebuffer byte address, page*COLS + col
//   fb_rdata_i      framebuffer byte, valid RD_LAT cycles after fb_addr_o
//   i2c_start_o     1-cycle byte command to the I2C master
//   i2c_dcn_o       0 = command byte, 1 = data byte
//   i2c_data_o      byte for the I2C master, held until the next i2c_start_o
//   i2c_busy_i      I2C master busy
//   ready_o         high while idle
//   frame_done_o    1-cycle pulse once the last data byte of a frame is accepted
//   fps_o           toggles on every frame_done_o
module oled_frame_streamer #(
  parameter int unsigned PWR_DELAY = 8000000,
  parameter int unsigned GAP       = 5,
  parameter int unsigned PAGES     = 8,
  parameter int unsigned COLS      = 128,
  parameter int unsigned RD_LAT    = 1,
  parameter logic [7:0]  CONTRAST  = 8'h7F,
  parameter bit          FLIP      = 1'b0,
  localparam int unsigned ADDR_W   = (PAGES * COLS > 1) ? $clog2(PAGES * COLS) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cont_i,
  input  logic              frame_req_i,
  output logic [ADDR_W-1:0] fb_addr_o,
  input  logic [7:0]        fb_rdata_i,
  output logic              i2c_start_o,
  output logic              i2c_dcn_o,
  output logic [7:0]        i2c_data_o,
  input  logic              i2c_busy_i,
  output logic              ready_o,
  output logic              frame_done_o,
  output logic              fps_o
);

  localparam int unsigned PwrW = (PWR_DELAY > 0) ? $clog2(PWR_DELAY + 1) : 1;
  localparam int unsigned GapW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [3:0]  InitLen = 4'd10;

  typedef enum logic [2:0] {
    StPwr,
    StInit,
    StIdle,
    StPgCmd,
    StFetch,
    StSend,
    StFend
  } state_e;

  state_e            state_q;
  logic [PwrW-1:0]   pwr_cnt_q;
  logic [GapW-1:0]   gap_cnt_q;
  logic              tx_wait_q;   // a byte is outstanding (gap or busy wait)
  logic [3:0]        idx_q;       // next byte index within INIT or PG_CMD
  logic [1:0]        lat_cnt_q;
  logic [2:0]        page_q;
  logic [6:0]        col_q;
  logic [ADDR_W-1:0] addr_q;
  logic              pending_q;
  logic              start_q;
  logic              dcn_q;
  logic [7:0]        data_q;
  logic              ready_q;
  logic              frame_done_q;
  logic              fps_q;

  logic              tx_done;

  function automatic logic [7:0] init_cmd(input logic [3:0] i);
    logic [7:0] c;
    case (i)
      4'd0:    c = 8'hAF;
      4'd1:    c = 8'hA6;
      4'd2:    c = 8'h20;
      4'd3:    c = 8'h02;
      4'd4:    c = 8'h8D;
      4'd5:    c = 8'h14;
      4'd6:    c = 8'h81;
      4'd7:    c = CONTRAST;
      4'd8:    c = FLIP ? 8'hA1 : 8'hA0;
      4'd9:    c = FLIP ? 8'hC8 : 8'hC0;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  // Page preamble: low column 0, high column 0, page address.
  function automatic logic [7:0] pg_cmd(input logic [3:0] i, input logic [2:0] page);
    logic [7:0] c;
    case (i)
      4'd0:    c = 8'h00;
      4'd1:    c = 8'h10;
      default: c = 8'hB0 | {5'b0, page};
    endcase
    return c;
  endfunction

  // The previous byte has had its GAP cycles and the master has gone idle.
  assign tx_done = tx_wait_q && (gap_cnt_q == '0) && !i2c_busy_i;

  // Every byte launch sets start/data/dcn, reloads the gap counter and marks the
  // byte outstanding in the same edge, so the next byte follows on the very edge
  // that tx_done is seen.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StPwr;
      pwr_cnt_q    <= PwrW'(PWR_DELAY);
      gap_cnt_q    <= '0;
      tx_wait_q    <= 1'b0;
      idx_q        <= '0;
      lat_cnt_q    <= '0;
      page_q       <= '0;
      col_q        <= '0;
      addr_q       <= '0;
      pending_q    <= 1'b0;
      start_q      <= 1'b0;
      dcn_q        <= 1'b0;
      data_q       <= '0;
      ready_q      <= 1'b0;
      frame_done_q <= 1'b0;
      fps_q        <= 1'b0;
    end else begin
      start_q      <= 1'b0;
      frame_done_q <= 1'b0;

      if (tx_wait_q && (gap_cnt_q != '0)) begin
        gap_cnt_q <= gap_cnt_q - 1'b1;
      end

      if (frame_req_i && (state_q != StIdle)) begin
        pending_q <= 1'b1;
      end

      unique case (state_q)
        StPwr: begin
          if (pwr_cnt_q == '0) begin
            start_q   <= 1'b1;
            dcn_q     <= 1'b0;
            data_q    <= init_cmd(4'd0);
            gap_cnt_q <= GapW'(GAP);
            tx_wait_q <= 1'b1;
            idx_q     <= 4'd1;
            state_q   <= StInit;
          end else begin
            pwr_cnt_q <= pwr_cnt_q - 1'b1;
          end
        end

        StInit: begin
          if (tx_done) begin
            if (idx_q == InitLen) begin
              tx_wait_q <= 1'b0;
              ready_q   <= 1'b1;
              state_q   <= StIdle;
            end else begin
              start_q   <= 1'b1;
              dcn_q     <= 1'b0;
              data_q    <= init_cmd(idx_q);
              gap_cnt_q <= GapW'(GAP);
              tx_wait_q <= 1'b1;
              idx_q     <= idx_q + 1'b1;
            end
          end
        end

        StIdle: begin
          if (cont_i || frame_req_i || pending_q) begin
            ready_q   <= 1'b0;
            pending_q <= 1'b0;
            page_q    <= '0;
            col_q     <= '0;
            addr_q    <= '0;
            start_q   <= 1'b1;
            dcn_q     <= 1'b0;
            data_q    <= pg_cmd(4'd0, 3'd0);
            gap_cnt_q <= GapW'(GAP);
            tx_wait_q <= 1'b1;
            idx_q     <= 4'd1;
            state_q   <= StPgCmd;
          end
        end

        StPgCmd: begin
          if (tx_done) begin
            if (idx_q == 4'd3) begin
              tx_wait_q <= 1'b0;
              lat_cnt_q <= 2'(RD_LAT);
              state_q   <= StFetch;
            end else begin
              start_q   <= 1'b1;
              dcn_q     <= 1'b0;
              data_q    <= pg_cmd(idx_q, page_q);
              gap_cnt_q <= GapW'(GAP);
              tx_wait_q <= 1'b1;
              idx_q     <= idx_q + 1'b1;
            end
          end
        end

        // fb_addr_o has been stable since entry; RD_LAT edges later the RAM output
        // is valid and is captured straight into the outgoing data register.
        StFetch: begin
          if (lat_cnt_q == '0) begin
            start_q   <= 1'b1;
            dcn_q     <= 1'b1;
            data_q    <= fb_rdata_i;
            gap_cnt_q <= GapW'(GAP);
            tx_wait_q <= 1'b1;
            state_q   <= StSend;
          end else begin
            lat_cnt_q <= lat_cnt_q - 1'b1;
          end
        end

        StSend: begin
          if (tx_done) begin
            tx_wait_q <= 1'b0;
            if (col_q != 7'(COLS - 1)) begin
              col_q     <= col_q + 1'b1;
              addr_q    <= addr_q + 1'b1;
              lat_cnt_q <= 2'(RD_LAT);
              state_q   <= StFetch;
            end else if (page_q != 3'(PAGES - 1)) begin
              page_q    <= page_q + 1'b1;
              col_q     <= '0;
              addr_q    <= addr_q + 1'b1;
              start_q   <= 1'b1;
              dcn_q     <= 1'b0;
              data_q    <= pg_cmd(4'd0, 3'd0);
              gap_cnt_q <= GapW'(GAP);
              tx_wait_q <= 1'b1;
              idx_q     <= 4'd1;
              state_q   <= StPgCmd;
            end else begin
              // Address stays on the last byte until the next frame starts.
              frame_done_q <= 1'b1;
              fps_q        <= ~fps_q;
              state_q      <= StFend;
            end
          end
        end

        StFend: begin
          ready_q <= 1'b1;
          state_q <= StIdle;
        end

        default: begin
          state_q <= StPwr;
        end
      endcase
    end
  end

  assign fb_addr_o    = addr_q;
  assign i2c_start_o  = start_q;
  assign i2c_dcn_o    = dcn_q;
  assign i2c_data_o   = data_q;
  assign ready_o      = ready_q;
  assign frame_done_o = frame_done_q;
  assign fps_o        = fps_q;

endmodule

// File: tb/tb_oled_frame_streamer.sv
module tb_oled_frame_streamer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cont;
  logic       frame_req;
  logic [2:0] fb_addr;
  logic [7:0] fb_rdata;
  logic       i2c_start;
  logic       i2c_dcn;
  logic [7:0] i2c_data;
  logic       i2c_busy;
  logic       ready;
  logic       frame_done;
  logic       fps;

  always #5 clk = ~clk;

  oled_frame_streamer #(
    .PWR_DELAY(10),
    .GAP      (2),
    .PAGES    (2),
    .COLS     (4),
    .RD_LAT   (2),
    .CONTRAST (8'h7F),
    .FLIP     (1'b0)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cont_i      (cont),
    .frame_req_i (frame_req),
    .fb_addr_o   (fb_addr),
    .fb_rdata_i  (fb_rdata),
    .i2c_start_o (i2c_start),
    .i2c_dcn_o   (i2c_dcn),
    .i2c_data_o  (i2c_data),
    .i2c_busy_i  (i2c_busy),
    .ready_o     (ready),
    .frame_done_o(frame_done),
    .fps_o       (fps)
  );

  // Framebuffer RAM with RAM[a] = a and two cycles of read latency.
  logic [7:0] ram_p1;
  always @(posedge clk) begin
    ram_p1   <= {5'b0, fb_addr};
    fb_rdata <= ram_p1;
  end

  // I2C slave model: idle, or busy for 7 cycles after each start.
  bit busy_mode = 1'b0;
  int busy_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst) busy_cnt <= 0;
    else if (busy_mode && i2c_start) busy_cnt <= 7;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign i2c_busy = (busy_cnt != 0);

  int cyc;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else cyc <= cyc + 1;
  end

  typedef struct {
    logic       dcn;
    logic [7:0] data;
    int         cyc;
  } ev_t;

  typedef struct {
    logic       dcn;
    logic [7:0] data;
  } vec_t;

  ev_t        log_q[$];
  logic       fps_hist[$];
  int         fd_cnt = 0;
  int         stable_err = 0;
  logic [8:0] last_byte;
  bit         have_last = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      have_last <= 1'b0;
    end else begin
      if (i2c_start) begin
        log_q.push_back(ev_t'{i2c_dcn, i2c_data, cyc});
        last_byte <= {i2c_dcn, i2c_data};
        have_last <= 1'b1;
      end else if (have_last && ({i2c_dcn, i2c_data} !== last_byte)) begin
        stable_err <= stable_err + 1;
      end
      if (frame_done) begin
        fd_cnt <= fd_cnt + 1;
        fps_hist.push_back(fps);
      end
    end
  end

  vec_t init_tbl[10];
  vec_t frame_tbl[14];
  int   checks = 0;
  int   failures = 0;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic pulse_req();
    frame_req = 1'b1;
    tick();
    frame_req = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) tick();
    log_q.delete();
    fps_hist.delete();
    rst = 1'b0;
  endtask

  task automatic wait_ready(input string name, input int bound);
    int n = 0;
    while (!ready && n < bound) begin
      tick();
      n++;
    end
    chk({name, "_ready"}, 32'(ready), 32'd1);
  endtask

  task automatic wait_fd(input string name, input int target, input int bound);
    int n = 0;
    while (fd_cnt < target && n < bound) begin
      tick();
      n++;
    end
    chk({name, "_frame_done_seen"}, 32'(fd_cnt >= target), 32'd1);
  endtask

  // Compares the captured byte log against the init (sel=0) or frame (sel=1) table.
  task automatic check_bytes(input string tag, input int off, input int n, input bit sel);
    for (int i = 0; i < n; i++) begin
      vec_t e;
      e = sel ? frame_tbl[i] : init_tbl[i];
      if (off + i < log_q.size()) begin
        chk($sformatf("%s_byte%0d", tag, i), 32'({log_q[off+i].dcn, log_q[off+i].data}),
            32'({e.dcn, e.data}));
      end else begin
        chk($sformatf("%s_byte%0d_missing", tag, i), 32'(log_q.size()), 32'(off + i + 1));
      end
    end
  endtask

  task automatic check_init(input string tag);
    if (log_q.size() > 0) chk({tag, "_first_start_cycle"}, 32'(log_q[0].cyc), 32'd11);
    else chk({tag, "_first_start_cycle"}, 32'd0, 32'd11);
    check_bytes(tag, 0, 10, 1'b0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   base;
    int   bad_cmd;
    bit   found;
    logic [7:0] init_bytes [10];
    init_bytes = '{8'hAF, 8'hA6, 8'h20, 8'h02, 8'h8D, 8'h14, 8'h81, 8'h7F, 8'hA0, 8'hC0};
    for (int i = 0; i < 10; i++) init_tbl[i] = '{1'b0, init_bytes[i]};
    frame_tbl[0] = '{1'b0, 8'h00};
    frame_tbl[1] = '{1'b0, 8'h10};
    frame_tbl[2] = '{1'b0, 8'hB0};
    for (int i = 0; i < 4; i++) frame_tbl[3 + i] = '{1'b1, 8'(i)};
    frame_tbl[7] = '{1'b0, 8'h00};
    frame_tbl[8] = '{1'b0, 8'h10};
    frame_tbl[9] = '{1'b0, 8'hB1};
    for (int i = 0; i < 4; i++) frame_tbl[10 + i] = '{1'b1, 8'(4 + i)};

    rst = 1'b1;
    cont = 1'b0;
    frame_req = 1'b0;
    tick();
    tick();
    chk("rst_start", 32'(i2c_start), 32'd0);
    chk("rst_dcn", 32'(i2c_dcn), 32'd0);
    chk("rst_data", 32'(i2c_data), 32'd0);
    chk("rst_addr", 32'(fb_addr), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_fps", 32'(fps), 32'd0);
    rst = 1'b0;

    // Power-up wait and init list, idle slave.
    wait_ready("init", 300);
    check_init("init");
    chk("init_count", 32'(log_q.size()), 32'd10);

    // Single frame.
    log_q.delete();
    base = fd_cnt;
    pulse_req();
    wait_fd("frame1", base + 1, 1000);
    repeat (5) tick();
    check_bytes("frame1", 0, 14, 1'b1);
    chk("frame1_count", 32'(log_q.size()), 32'd14);
    chk("frame1_done_pulses", 32'(fd_cnt - base), 32'd1);
    chk("frame1_fps", 32'(fps), 32'd1);
    chk("frame1_ready", 32'(ready), 32'd1);
    chk("frame1_addr_no_wrap", 32'(fb_addr), 32'd7);

    // Two requests during a frame collapse to one extra frame.
    log_q.delete();
    base = fd_cnt;
    pulse_req();
    repeat (10) tick();
    pulse_req();
    repeat (5) tick();
    pulse_req();
    wait_fd("double", base + 2, 2000);
    repeat (100) tick();
    chk("double_done_pulses", 32'(fd_cnt - base), 32'd2);
    chk("double_byte_count", 32'(log_q.size()), 32'd28);
    chk("double_ready", 32'(ready), 32'd1);
    chk("double_fps", 32'(fps), 32'd1);
    check_bytes("double_f2", 14, 14, 1'b1);

    // Busy slave: start spacing and init after a fresh reset.
    busy_mode = 1'b1;
    do_reset();
    wait_ready("busy_init", 500);
    check_init("busy_init");
    for (int i = 1; i < 10 && i < log_q.size(); i++) begin
      chk($sformatf("busy_spacing%0d", i), 32'(log_q[i].cyc - log_q[i-1].cyc), 32'd9);
    end

    // Continuous refresh, three frames.
    log_q.delete();
    fps_hist.delete();
    base = fd_cnt;
    cont = 1'b1;
    wait_fd("cont", base + 3, 5000);
    cont = 1'b0;
    repeat (40) tick();
    chk("cont_done_pulses", 32'(fd_cnt - base), 32'd3);
    chk("cont_byte_count", 32'(log_q.size()), 32'd42);
    chk("cont_fps_hist_len", 32'(fps_hist.size()), 32'd3);
    if (fps_hist.size() == 3) begin
      chk("cont_fps0", 32'(fps_hist[0]), 32'd1);
      chk("cont_fps1", 32'(fps_hist[1]), 32'd0);
      chk("cont_fps2", 32'(fps_hist[2]), 32'd1);
    end
    bad_cmd = 0;
    foreach (log_q[i]) begin
      if (!log_q[i].dcn && !(log_q[i].data inside {8'h00, 8'h10, 8'hB0, 8'hB1})) bad_cmd++;
    end
    chk("cont_no_init_repeat", 32'(bad_cmd), 32'd0);
    chk("cont_ready", 32'(ready), 32'd1);

    // Reset while sending page 1 col 2 (RAM byte 6).
    busy_mode = 1'b0;
    tick();
    log_q.delete();
    base = fd_cnt;
    pulse_req();
    found = 1'b0;
    for (int n = 0; n < 500 && !found; n++) begin
      tick();
      if (i2c_start && i2c_dcn && i2c_data == 8'h06) found = 1'b1;
    end
    chk("rst_mid_found_byte6", 32'(found), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_start", 32'(i2c_start), 32'd0);
    chk("rst_mid_dcn", 32'(i2c_dcn), 32'd0);
    chk("rst_mid_data", 32'(i2c_data), 32'd0);
    chk("rst_mid_addr", 32'(fb_addr), 32'd0);
    chk("rst_mid_fps", 32'(fps), 32'd0);
    chk("rst_mid_ready", 32'(ready), 32'd0);
    repeat (3) tick();
    log_q.delete();
    rst = 1'b0;
    wait_ready("rst_mid_init", 300);
    check_init("rst_mid_init");
    chk("rst_mid_no_frame_done", 32'(fd_cnt - base), 32'd0);
    chk("data_stable_between_bytes", 32'(stable_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
